ones_frame_accumulator: RTL and testbench

- Downstream stage of the 4-bit ones counter. Consumes its 3-bit per-word popcount (0..4) under a valid/ready handshake.
- Sums the popcounts over a frame of FRAME_LEN words, then presents the frame total with a threshold flag under a valid/ready handshake.
- Gives the datapath a registered, per-frame "number of ones" figure built from the combinational counter's output.

---
 rtl/ones_frame_accumulator.sv | 93 +++++++++
 tb/tb_ones_frame_accumulator.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/ones_frame_accumulator.sv
// Frame accumulator behind the 4-bit ones counter: sums per-word popcounts over
// FRAME_LEN accepted words and hands the total plus a threshold flag downstream.
module ones_frame_accumulator #(
  parameter int unsigned FRAME_LEN = 8,
  parameter int unsigned SUM_W     = 6,
  parameter int unsigned THRESH    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  input  logic [2:0]       in_count,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SUM_W-1:0] sum,
  output logic             above_thresh,
  output logic             busy,
  output logic             err
);

  // state | meaning
  // IDLE  | waiting for start; last frame's sum still visible
  // ACCUM | accepting words, summing clamped popcounts
  // DONE  | result presented until out_ready
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int unsigned CNT_W = $clog2(FRAME_LEN + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);
  localparam logic [SUM_W-1:0] THRESH_V = SUM_W'(THRESH);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] word_cnt;
  logic             accept;
  logic             last_word;
  logic             bad_count;
  logic [2:0]       count_clamped;
  logic [SUM_W-1:0] sum_nxt;

  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == DONE);

  assign accept        = in_ready & in_valid;
  assign last_word     = (word_cnt == LAST_IDX);
  assign bad_count     = (in_count > 3'd4);
  assign count_clamped = bad_count ? 3'd4 : in_count;
  assign sum_nxt       = sum + SUM_W'(count_clamped);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ACCUM;
      ACCUM:   if (accept && last_word) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt != IDLE);
    end
  end

  // Result registers only move on start or on an accept, so DONE holds them stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum          <= '0;
      word_cnt     <= '0;
      err          <= 1'b0;
      above_thresh <= 1'b0;
    end else if (state == IDLE && start) begin
      sum          <= '0;
      word_cnt     <= '0;
      err          <= 1'b0;
      above_thresh <= 1'b0;
    end else if (accept) begin
      sum      <= sum_nxt;
      word_cnt <= word_cnt + CNT_W'(1);
      if (bad_count) err <= 1'b1;
      if (last_word) above_thresh <= (sum_nxt >= THRESH_V);
    end
  end

endmodule

// File: tb/tb_ones_frame_accumulator.sv
// Directed bench for ones_frame_accumulator (defaults FRAME_LEN=8, SUM_W=6, THRESH=16).
// Inputs change and outputs are sampled 1ns after the rising edge.
module tb_ones_frame_accumulator;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       in_valid = 1'b0;
  logic [2:0] in_count = 3'd0;
  logic       in_ready;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [5:0] sum;
  logic       above_thresh;
  logic       busy;
  logic       err;

  int n_chk  = 0;
  int n_fail = 0;

  ones_frame_accumulator #(.FRAME_LEN(8), .SUM_W(6), .THRESH(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .in_valid     (in_valid),
    .in_count     (in_count),
    .in_ready     (in_ready),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .sum          (sum),
    .above_thresh (above_thresh),
    .busy         (busy),
    .err          (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic send_word(input int cnt, input int gap);
    in_valid = 1'b0;
    for (int g = 0; g < gap; g++) step();
    in_valid = 1'b1;
    in_count = 3'(cnt);
    step();
    in_valid = 1'b0;
  endtask

  task automatic finish_frame(input string tag, input int exp_sum, input int exp_above,
                              input int exp_err);
    chk({tag, ".out_valid"}, int'(out_valid), 1);
    chk({tag, ".in_ready"}, int'(in_ready), 0);
    chk({tag, ".sum"}, int'(sum), exp_sum);
    chk({tag, ".above"}, int'(above_thresh), exp_above);
    chk({tag, ".err"}, int'(err), exp_err);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, ".drop_valid"}, int'(out_valid), 0);
    chk({tag, ".idle_busy"}, int'(busy), 0);
  endtask

  int cnt_a [8] = '{1, 0, 2, 1, 3, 0, 4, 4};
  int gap_a [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
  int cnt_b [8] = '{1, 1, 2, 2, 2, 2, 3, 3};
  int cnt_c [8] = '{1, 1, 7, 1, 1, 1, 1, 1};

  initial begin
    #12;
    chk("rst.sum", int'(sum), 0);
    chk("rst.in_ready", int'(in_ready), 0);
    chk("rst.out_valid", int'(out_valid), 0);
    chk("rst.busy", int'(busy), 0);
    chk("rst.err", int'(err), 0);
    chk("rst.above", int'(above_thresh), 0);
    rst_n = 1'b1;
    step();

    // Frame of eight 4s back-to-back.
    start_frame();
    chk("t1.busy", int'(busy), 1);
    in_valid = 1'b1;
    in_count = 3'd4;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t1.in_ready%0d", i), int'(in_ready), 1);
      step();
    end
    in_valid = 1'b0;
    finish_frame("t1", 32, 1, 0);
    chk("t1.sum_kept_idle", int'(sum), 32);

    // Gapped frame summing to 15, then a frame summing exactly to THRESH.
    start_frame();
    for (int i = 0; i < 8; i++) send_word(cnt_a[i], gap_a[i]);
    finish_frame("t2a", 15, 0, 0);
    start_frame();
    for (int i = 0; i < 8; i++) send_word(cnt_b[i], 0);
    finish_frame("t2b", 16, 1, 0);

    // Held in DONE with start asserted; result must not move.
    start_frame();
    for (int i = 0; i < 8; i++) send_word(3, 0);
    start = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("t3.hold_valid%0d", i), int'(out_valid), 1);
      chk($sformatf("t3.hold_sum%0d", i), int'(sum), 24);
      chk($sformatf("t3.hold_above%0d", i), int'(above_thresh), 1);
      step();
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    start = 1'b0;
    chk("t3.idle_valid", int'(out_valid), 0);
    chk("t3.idle_ready", int'(in_ready), 0);
    step();
    chk("t3.no_restart", int'(in_ready), 0);
    chk("t3.no_restart_busy", int'(busy), 0);

    // Out-of-range count is clamped to 4 and flags err until the next start.
    start_frame();
    for (int i = 0; i < 8; i++) send_word(cnt_c[i], 0);
    finish_frame("t4", 11, 0, 1);
    chk("t4.err_sticky_idle", int'(err), 1);
    start_frame();
    chk("t4.err_cleared", int'(err), 0);
    for (int i = 0; i < 8; i++) send_word(0, 0);
    finish_frame("t4b", 0, 0, 0);

    // Asynchronous reset after five words, between clock edges.
    start_frame();
    for (int i = 0; i < 5; i++) send_word(2, 0);
    chk("t5.partial_sum", int'(sum), 10);
    #3;
    rst_n = 1'b0;
    #1;
    chk("t5.rst_sum", int'(sum), 0);
    chk("t5.rst_in_ready", int'(in_ready), 0);
    chk("t5.rst_busy", int'(busy), 0);
    chk("t5.rst_out_valid", int'(out_valid), 0);
    rst_n = 1'b1;
    step();
    start_frame();
    for (int i = 0; i < 8; i++) send_word(2, 0);
    finish_frame("t5", 16, 1, 0);

    // in_valid alongside start in IDLE is not an accept.
    in_valid = 1'b1;
    in_count = 3'd4;
    start_frame();
    chk("t6.no_accept_sum", int'(sum), 0);
    in_count = 3'd1;
    for (int i = 0; i < 8; i++) step();
    in_valid = 1'b0;
    finish_frame("t6", 8, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
